// File: rtl/imm_field_encoder_if.sv
// Request/result bus of the immediate-field encoder: request side, result side,
// and the address/error bookkeeping signals that travel with the results.
interface imm_field_encoder_if #(
    parameter int ADDR_W   = 64,
    parameter int ERRCNT_W = 8
);
    logic                InValid;
    logic                InReady;
    logic [31:0]         InBase;
    logic [63:0]         InImm;
    logic [1:0]          Ctrl;
    logic                OutValid;
    logic                OutReady;
    logic [31:0]         OutInsn;
    logic                OutErr;
    logic [ADDR_W-1:0]   OutAddr;
    logic                AddrLoad;
    logic [ADDR_W-1:0]   AddrIn;
    logic [ERRCNT_W-1:0] ErrCount;

    modport master (
        output InValid, InBase, InImm, Ctrl, OutReady, AddrLoad, AddrIn,
        input  InReady, OutValid, OutInsn, OutErr, OutAddr, ErrCount
    );

    modport slave (
        input  InValid, InBase, InImm, Ctrl, OutReady, AddrLoad, AddrIn,
        output InReady, OutValid, OutInsn, OutErr, OutAddr, ErrCount
    );
endinterface

// File: rtl/imm_field_encoder.sv
// Packs a 64-bit immediate into the immediate field of a LEGv8 instruction word
// (I/D/B/CBZ formats) through a two-stage valid/ready pipeline.
module imm_field_encoder #(
    parameter int ADDR_W   = 64,
    parameter int ERRCNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 ResetL,
    imm_field_encoder_if.slave   bus
);
    logic                s1_valid;
    logic [31:0]         s1_base;
    logic [63:0]         s1_imm;
    logic [1:0]          s1_ctrl;

    logic                s2_valid;
    logic [31:0]         s2_insn;
    logic                s2_err;

    logic [ADDR_W-1:0]   addr_cnt;
    logic [ERRCNT_W-1:0] err_cnt;

    logic                s2_adv;
    logic                s1_adv;
    logic                in_hs;
    logic                out_hs;

    logic [31:0]         field_mask;
    logic [31:0]         field_val;
    logic                legal;
    logic [31:0]         enc_insn;

    assign s2_adv = !s2_valid || bus.OutReady;
    assign s1_adv = s2_adv || !s1_valid;
    assign in_hs  = bus.InValid && bus.InReady;
    assign out_hs = s2_valid && bus.OutReady;

    assign bus.InReady  = !s1_valid || s2_adv;
    assign bus.OutValid = s2_valid;
    assign bus.OutInsn  = s2_insn;
    assign bus.OutErr   = s2_err;
    assign bus.OutAddr  = addr_cnt;
    assign bus.ErrCount = err_cnt;

    // Legal means the decode-side extender would reproduce s1_imm exactly from the field.
    always_comb begin
        field_mask = 32'h0;
        field_val  = 32'h0;
        legal      = 1'b0;
        case (s1_ctrl)
            2'b00: begin
                field_mask = 32'h003F_FC00;
                field_val  = {10'b0, s1_imm[11:0], 10'b0};
                legal      = ~|s1_imm[63:12];
            end
            2'b01: begin
                field_mask = 32'h001F_F000;
                field_val  = {11'b0, s1_imm[8:0], 12'b0};
                legal      = (&s1_imm[63:8]) || (~|s1_imm[63:8]);
            end
            2'b10: begin
                field_mask = 32'h03FF_FFFF;
                field_val  = {6'b0, s1_imm[27:2]};
                legal      = (s1_imm[1:0] == 2'b00) &&
                             ((&s1_imm[63:27]) || (~|s1_imm[63:27]));
            end
            default: begin
                field_mask = 32'h00FF_FFE0;
                field_val  = {8'b0, s1_imm[20:2], 5'b0};
                legal      = (s1_imm[1:0] == 2'b00) &&
                             ((&s1_imm[63:20]) || (~|s1_imm[63:20]));
            end
        endcase
        enc_insn = (s1_base & ~field_mask) | (legal ? field_val : 32'h0);
    end

    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            s1_valid <= 1'b0;
            s1_base  <= 32'h0;
            s1_imm   <= 64'h0;
            s1_ctrl  <= 2'b00;
        end else if (s1_adv) begin
            s1_valid <= in_hs;
            if (in_hs) begin
                s1_base <= bus.InBase;
                s1_imm  <= bus.InImm;
                s1_ctrl <= bus.Ctrl;
            end
        end
    end

    // S2 only reloads when it advances, so outputs stay frozen under backpressure.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            s2_valid <= 1'b0;
            s2_insn  <= 32'h0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_insn <= enc_insn;
                s2_err  <= !legal;
            end
        end
    end

    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            addr_cnt <= '0;
        end else if (bus.AddrLoad) begin
            addr_cnt <= bus.AddrIn;
        end else if (out_hs) begin
            addr_cnt <= addr_cnt + ADDR_W'(4);
        end
    end

    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            err_cnt <= '0;
        end else if (out_hs && s2_err && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed bench for imm_field_encoder: a scoreboard queue is filled on accept and
// drained by a negedge monitor that checks each delivered word, error flag and address.
module tb_imm_field_encoder;
    logic clk = 1'b0;
    logic resetL;

    imm_field_encoder_if #(.ADDR_W(64), .ERRCNT_W(8)) bus ();

    imm_field_encoder #(.ADDR_W(64), .ERRCNT_W(8)) dut (
        .CLK    (clk),
        .ResetL (resetL),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          nCmp  = 0;
    int          nFail = 0;
    logic [63:0] modelAddr = 64'h0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nCmp++;
        assert (obs === expv) else begin
            nFail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives one request (from posedge+1) and pushes its expectation once accepted.
    task automatic applyStimulus(input logic [31:0] base, input logic [63:0] imm,
                                 input logic [1:0] ctrl, input logic [31:0] expInsn,
                                 input logic expErr);
        bit acc = 1'b0;
        bus.InValid = 1'b1;
        bus.InBase  = base;
        bus.InImm   = imm;
        bus.Ctrl    = ctrl;
        for (int c = 0; c < 64 && !acc; c++) begin
            @(negedge clk);
            acc = bus.InReady;
            @(posedge clk);
            #1;
        end
        bus.InValid = 1'b0;
        if (acc) sb.push_back('{expInsn, expErr});
        else checkOutput("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic waitDrain();
        int c = 0;
        while (sb.size() != 0 && c < 400) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // The address model follows the load-over-increment rule independently of the DUT.
    always @(negedge clk) begin
        if (!resetL) begin
            modelAddr = 64'h0;
        end else begin
            if (bus.OutValid && bus.OutReady) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", 64'(sb.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("out_insn", 64'(bus.OutInsn), 64'(e.insn));
                    checkOutput("out_err", 64'(bus.OutErr), 64'(e.err));
                    checkOutput("out_addr", bus.OutAddr, modelAddr);
                end
            end
            if (bus.AddrLoad) modelAddr = bus.AddrIn;
            else if (bus.OutValid && bus.OutReady) modelAddr = modelAddr + 64'd4;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetL       = 1'b0;
        bus.InValid  = 1'b0;
        bus.InBase   = 32'h0;
        bus.InImm    = 64'h0;
        bus.Ctrl     = 2'b00;
        bus.OutReady = 1'b1;
        bus.AddrLoad = 1'b0;
        bus.AddrIn   = 64'h0;

        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_outvalid", 64'(bus.OutValid), 64'd0);
        checkOutput("rst_inready", 64'(bus.InReady), 64'd1);
        checkOutput("rst_outinsn", 64'(bus.OutInsn), 64'd0);
        checkOutput("rst_outerr", 64'(bus.OutErr), 64'd0);
        checkOutput("rst_outaddr", bus.OutAddr, 64'd0);
        checkOutput("rst_errcount", 64'(bus.ErrCount), 64'd0);
        resetL = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] I-format and pipeline latency");
        applyStimulus(32'h9100_0000, 64'hFFF, 2'b00, 32'h913F_FC00, 1'b0);
        @(negedge clk);
        checkOutput("lat_not_yet", 64'(bus.OutValid), 64'd0);
        @(negedge clk);
        checkOutput("lat_valid", 64'(bus.OutValid), 64'd1);
        checkOutput("first_addr", bus.OutAddr, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("addr_after_hs", bus.OutAddr, 64'd4);
        @(posedge clk);
        #1;

        $display("[TB] format boundaries, back-to-back");
        applyStimulus(32'hF840_0000, 64'hFFFF_FFFF_FFFF_FF00, 2'b01, 32'hF850_0000, 1'b0);
        applyStimulus(32'hF840_0000, 64'd256, 2'b01, 32'hF840_0000, 1'b1);
        applyStimulus(32'h9100_0000, 64'h1000, 2'b00, 32'h9100_0000, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 64'h5A5, 2'b00, 32'hFFD6_97FF, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 64'hFF, 2'b01, 32'hFFEF_FFFF, 1'b0);
        applyStimulus(32'h1400_0000, 64'hFFFF_FFFF_FFFF_FFFC, 2'b10, 32'h17FF_FFFF, 1'b0);
        applyStimulus(32'h1400_0000, 64'h07FF_FFFC, 2'b10, 32'h15FF_FFFF, 1'b0);
        applyStimulus(32'h1400_0000, 64'h0800_0000, 2'b10, 32'h1400_0000, 1'b1);
        applyStimulus(32'hB400_0003, 64'h6, 2'b11, 32'hB400_0003, 1'b1);
        applyStimulus(32'hB400_0003, 64'h0F_FFFC, 2'b11, 32'hB47F_FFE3, 1'b0);
        waitDrain();
        checkOutput("errcount_4", 64'(bus.ErrCount), 64'd4);

        $display("[TB] backpressure");
        bus.AddrLoad = 1'b1;
        bus.AddrIn   = 64'h0;
        @(posedge clk);
        #1;
        bus.AddrLoad = 1'b0;
        bus.OutReady = 1'b0;
        fork
            begin
                for (int k = 1; k <= 5; k++)
                    applyStimulus(32'h9100_0000, 64'(k), 2'b00,
                                  32'h9100_0000 | (32'(k) << 10), 1'b0);
            end
            begin
                @(negedge clk);
                checkOutput("bp_ready_0", 64'(bus.InReady), 64'd1);
                @(negedge clk);
                checkOutput("bp_ready_1", 64'(bus.InReady), 64'd1);
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    checkOutput("bp_ready_low", 64'(bus.InReady), 64'd0);
                    checkOutput("bp_valid", 64'(bus.OutValid), 64'd1);
                    checkOutput("bp_insn_hold", 64'(bus.OutInsn), 64'h9100_0400);
                    checkOutput("bp_err_hold", 64'(bus.OutErr), 64'd0);
                    checkOutput("bp_addr_hold", bus.OutAddr, 64'd0);
                end
                @(posedge clk);
                #1;
                bus.OutReady = 1'b1;
            end
        join
        waitDrain();
        checkOutput("bp_final_addr", bus.OutAddr, 64'd20);

        $display("[TB] address load during handshake");
        bus.OutReady = 1'b0;
        applyStimulus(32'h9100_0000, 64'd7, 2'b00, 32'h9100_1C00, 1'b0);
        for (int c = 0; c < 20 && !bus.OutValid; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("load_valid", 64'(bus.OutValid), 64'd1);
        bus.AddrLoad = 1'b1;
        bus.AddrIn   = 64'h400;
        bus.OutReady = 1'b1;
        @(posedge clk);
        #1;
        bus.AddrLoad = 1'b0;
        @(negedge clk);
        checkOutput("addr_load_wins", bus.OutAddr, 64'h400);
        @(posedge clk);
        #1;
        applyStimulus(32'h9100_0000, 64'd8, 2'b00, 32'h9100_2000, 1'b0);
        waitDrain();

        $display("[TB] error counter saturation");
        for (int i = 0; i < 300; i++)
            applyStimulus(32'h9100_0000, 64'h1000, 2'b00, 32'h9100_0000, 1'b1);
        waitDrain();
        checkOutput("errcount_sat", 64'(bus.ErrCount), 64'd255);

        $display("[TB] reset mid-operation");
        bus.OutReady = 1'b0;
        applyStimulus(32'h9100_0000, 64'd1, 2'b00, 32'h9100_0400, 1'b0);
        applyStimulus(32'h9100_0000, 64'd2, 2'b00, 32'h9100_0800, 1'b0);
        #2;
        resetL = 1'b0;
        #1;
        checkOutput("midrst_outvalid", 64'(bus.OutValid), 64'd0);
        checkOutput("midrst_inready", 64'(bus.InReady), 64'd1);
        checkOutput("midrst_outaddr", bus.OutAddr, 64'd0);
        checkOutput("midrst_errcount", 64'(bus.ErrCount), 64'd0);
        checkOutput("midrst_outinsn", 64'(bus.OutInsn), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        resetL       = 1'b1;
        bus.OutReady = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(32'h9100_0000, 64'h123, 2'b00, 32'h9104_8C00, 1'b0);
        waitDrain();
        checkOutput("post_rst_addr", bus.OutAddr, 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
